muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide execute unit adding RV32M/RV64M support to the pipelined datapath. It sits in the EX stage beside the ALU. The unit accepts one operation per start pulse and asserts busy so the hazard unit can stall the F, D and E stages. It returns a registered result with a one-cycle done pulse, and it aborts cleanly on an EX flush.

Parameters:
XLEN, 32, operand and result width; legal values are 32 and 64.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-low
start  input  1  request; sampled only in IDLE
flush  input  1  abort current op (EX flush from hazard unit)
op  input  3  funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
src_a  input  XLEN  rs1 operand (post-forwarding)
src_b  input  XLEN  rs2 operand (post-forwarding)
busy  output  1  unit occupied; OR into StallF/StallD and hold the E register
done  output  1  one-cycle pulse; result valid this cycle
result  output  XLEN  registered result, held until the next accepted start

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE, busy=0, done=0, result=0.
  - Counter and internal registers are cleared.
- States and transitions:
  - IDLE -> CALC on start & ~flush. In the same edge: latch op and sign flags, latch the absolute values of the operands where op is signed, set counter=XLEN.
  - CALC runs one radix-2 step per cycle and decrements the counter. The multiply step is shift-add into a 2*XLEN product. The divide step is restoring shift-subtract.
  - CALC -> FIX when the counter reaches 1 on the current step.
  - FIX applies sign correction, then selects the low or high product half, or the quotient or remainder.
  - FIX -> DONE with result registered.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
- Latency: start edge to done is XLEN+2 cycles (34 for XLEN=32).
- Special cases go IDLE -> DONE directly, with done one cycle after start:
  - Divide by zero: DIV/DIVU result all ones; REM/REMU result = src_a.
  - Signed overflow (src_a = most-negative, src_b = all ones): DIV result = src_a; REM result = 0.
- Sign rules:
  - MULH treats both operands as signed.
  - MULHSU treats src_a as signed and src_b as unsigned.
  - The remainder takes the sign of the dividend.
  - The quotient is negated when the operand signs differ.
- busy = (state != IDLE). busy is not asserted combinationally on start; the hazard unit stalls on (start | busy).
- start while busy is ignored; operands are not re-sampled.
- flush in any state: next edge -> IDLE, done suppressed, result unchanged.
- flush together with start in IDLE: the start is dropped.
- flush in DONE: the done pulse is still 1 that cycle (already committed); the unit goes to IDLE.
- Reset asserted mid-operation: the unit returns to IDLE immediately and no done is issued.
- Back-to-back: a new start is accepted in the cycle after DONE (IDLE).

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL* ops bypass CALC. IDLE -> FIX computes a single-cycle 2*XLEN product. Multiply latency is 2. Divide is unchanged.
- Undefined: all ops take the iterative path described above.
- Port list and timing of special cases are identical in both builds.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op localparams (MUL=3'b000 … REMU=3'b111);
  - the state encoding IDLE/CALC/FIX/DONE;
  - helper functions is_div(op) and is_signed_a/b(op).
- Natural sub-module: muldiv_iter_core. It holds the per-cycle shift-add/shift-sub step and the 2*XLEN accumulator. The FSM, special-case detection and sign fix remain in muldiv_unit.

Test Plan:
- MUL src_a=7, src_b=0xFFFFFFFD -> done at cycle 34, result=0xFFFFFFEB; busy high cycles 1..34.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU -> 5 at cycle 1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0 at cycle 1.
- flush at cycle 10 of a DIV -> no done, busy=0 at cycle 11, previous result unchanged. A start at cycle 11 completes normally. A start with flush in the same cycle -> ignored.
- rst pulled low at cycle 5 of a MUL -> busy=0, done=0, result=0 asynchronously. After release, MUL 3x4 -> 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide execute unit.
package muldiv_pkg;

   // funct3 encodings of the M-extension operations
   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Divide family is funct3[2] set
   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // src_a is interpreted as signed for MULH, MULHSU, DIV, REM
   function automatic logic is_signed_a(input logic [2:0] op);
      return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
   endfunction

   // src_b is interpreted as signed for MULH, DIV, REM
   function automatic logic is_signed_b(input logic [2:0] op);
      return (op == MULH) || (op == DIV) || (op == REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 datapath: shift-add multiply and restoring shift-subtract divide on
// a 2*XLEN accumulator. Optional macro MULDIV_FAST_MUL_EN loads the full
// product in one cycle instead of iterating.
module muldiv_iter_core #(
   parameter int unsigned XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   a_abs,
   input  logic [XLEN-1:0]   b_abs,
   output logic [2*XLEN-1:0] acc
);

   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN-1:0]   diff;
   logic              ge;

   // Next accumulator: load operands, or advance one multiply/divide step
   always_comb begin
      acc_d   = acc_q;
      b_d     = b_q;
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
      rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      ge      = rem_sh >= {1'b0, b_q};
      diff    = rem_sh[XLEN-1:0] - b_q;
      if (load) begin
         b_d = b_abs;
`ifdef MULDIV_FAST_MUL_EN
         acc_d = is_div ? {{XLEN{1'b0}}, a_abs}
                        : (2*XLEN)'(a_abs) * (2*XLEN)'(b_abs);
`else
         acc_d = {{XLEN{1'b0}}, a_abs};
`endif
      end else if (step) begin
         if (is_div) begin
            acc_d = ge ? {diff, acc_q[XLEN-2:0], 1'b1}
                       : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
         end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
         end
      end
   end

   // Accumulator and latched multiplicand/divisor
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= acc_d;
         b_q   <= b_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Optional macro MULDIV_FAST_MUL_EN: multiplies skip CALC (latency 2).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic              sign_a_q, sign_a_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              sign_a, sign_b, div_zero, div_ovf;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic              core_load, core_step;
   logic [2*XLEN-1:0] acc, prod;
   logic [XLEN-1:0]   quot, rem, fix_val;

   assign sign_a   = is_signed_a(op) & src_a[XLEN-1];
   assign sign_b   = is_signed_b(op) & src_b[XLEN-1];
   assign a_abs    = sign_a ? -src_a : src_a;
   assign b_abs    = sign_b ? -src_b : src_b;
   assign div_zero = is_div(op) & (src_b == '0);
   assign div_ovf  = is_div(op) & is_signed_b(op) & (src_a == MOST_NEG) & (src_b == '1);

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (core_load),
      .step   (core_step),
      .is_div (is_div(state_q == IDLE ? op : op_q)),
      .a_abs  (a_abs),
      .b_abs  (b_abs),
      .acc    (acc)
   );

   // Sign correction and result selection for the FIX state
   always_comb begin
      prod = neg_q ? -acc : acc;
      quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = sign_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op_q)
         MUL:                  fix_val = prod[XLEN-1:0];
         MULH, MULHSU, MULHU:  fix_val = prod[2*XLEN-1:XLEN];
         DIV, DIVU:            fix_val = quot;
         default:              fix_val = rem;
      endcase
   end

   // Next-state, sequencing and registered-output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      neg_d     = neg_q;
      sign_a_d  = sign_a_q;
      result_d  = result_q;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               op_d     = op;
               neg_d    = sign_a ^ sign_b;
               sign_a_d = sign_a;
               if (div_zero) begin
                  result_d = op[1] ? src_a : '1;
                  state_d  = DONE;
               end else if (div_ovf) begin
                  result_d = op[1] ? '0 : src_a;
                  state_d  = DONE;
               end else begin
                  core_load = 1'b1;
                  cnt_d     = CNT_W'(XLEN);
`ifdef MULDIV_FAST_MUL_EN
                  state_d   = is_div(op) ? CALC : FIX;
`else
                  state_d   = CALC;
`endif
               end
            end
         end
         CALC: begin
            core_step = 1'b1;
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = FIX;
         end
         FIX: begin
            result_d = fix_val;
            state_d  = DONE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         sign_a_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         sign_a_q <= sign_a_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed table, random ops
// against an arithmetic reference model, and flush/reset sequences.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        busy, done;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst_n),
      .start  (start),
      .flush  (flush),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference result from RISC-V M-extension arithmetic rules
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] p;
      longint      sa, sb, ub;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      ia = $signed(a);
      ib = $signed(b);
      case (o)
         MUL:    begin p = 64'(sa * sb); return p[31:0]; end
         MULH:   begin p = 64'(sa * sb); return p[63:32]; end
         MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
         MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
         DIV:    begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(ia / ib);
         end
         DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM:    begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Expected start-to-done latency in cycles
   function automatic int lat_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o[2] && b == 0) return 1;
      if ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!o[2]) return 2;
`endif
      return 34;
   endfunction

   // Issue one op from an idle sample point; garbage start/operands while busy
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm);
      int cyc;
      logic busy_bad;
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'($urandom); op = 3'($urandom); src_a = $urandom; src_b = $urandom;
      cyc = 1;
      busy_bad = 1'b0;
      while (!done && cyc < 200) begin
         if (!busy) busy_bad = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check({nm, " latency"}, 64'(cyc), 64'(lat_of(o, a, b)));
      check({nm, " result"}, 64'(result), 64'(exp));
      check({nm, " busy"}, 64'({busy_bad, busy}), 64'(2'b01));
      @(posedge clk); #1;
      check({nm, " idle"}, 64'({busy, done, result}), 64'({2'b00, exp}));
   endtask

   vec_t vecs[12];

   initial begin
      logic [31:0] prev;
      logic        seen_done;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul 7x-3"};
      vecs[1]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu"};
      vecs[2]  = '{MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, "mulh"};
      vecs[3]  = '{MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, "mulhsu"};
      vecs[4]  = '{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div -7/2"};
      vecs[5]  = '{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem -7/2"};
      vecs[6]  = '{DIVU,   32'd100,        32'd7,         32'd14,        "divu 100/7"};
      vecs[7]  = '{REMU,   32'd100,        32'd7,         32'd2,         "remu 100/7"};
      vecs[8]  = '{DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, "divu by 0"};
      vecs[9]  = '{REMU,   32'd5,          32'd0,         32'd5,         "remu by 0"};
      vecs[10] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div ovf"};
      vecs[11] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, "rem ovf"};

      // Reset state
      #12;
      check("reset outputs", 64'({busy, done, result}), 64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors, issued back-to-back
      foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

      // Randomized ops with boundary-biased operands
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom);
         case ($urandom_range(0, 4))
            0: ra = 32'h8000_0000;
            1: ra = 32'hFFFF_FFFF;
            2: ra = 32'($urandom_range(0, 20));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         run_op(ro, ra, rb, ref_model(ro, ra, rb), "random");
      end

      // Flush at cycle 10 of a DIV
      prev = result;
      start = 1'b1; op = DIV; src_a = 32'd1000; src_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      seen_done = 1'b0;
      for (int c = 1; c < 10; c++) begin
         seen_done |= done;
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      seen_done |= done;
      check("flush abort", 64'({seen_done, busy, done, result}), 64'({3'b000, prev}));
      run_op(DIV, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, "after flush");

      // Start together with flush is dropped
      start = 1'b1; flush = 1'b1; op = MUL; src_a = 32'd9; src_b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      seen_done = busy;
      for (int c = 0; c < 40; c++) begin
         seen_done |= done | busy;
         @(posedge clk); #1;
      end
      check("start+flush dropped", 64'({seen_done, result}), 64'({1'b0, 32'hFFFF_FEB3}));

      // Flush during DONE: the pulse is already committed
      start = 1'b1; flush = 1'b0; op = DIVU; src_a = 32'd5; src_b = 32'd0;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b1;
      check("flush in done pulse", 64'({done, result}), 64'({1'b1, 32'hFFFF_FFFF}));
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush in done idle", 64'({busy, done}), 64'(0));

      // Async reset mid-MUL
      start = 1'b1; op = MUL; src_a = 32'd123; src_b = 32'd456;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 5; c++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("async reset", 64'({busy, done, result}), 64'(0));
      #1;
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         seen_done |= done | busy;
      end
      check("no done after reset", 64'(seen_done), 64'(0));
      run_op(MUL, 32'd3, 32'd4, 32'd12, "mul after reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
